// File: rtl/vdp_bbus_pkg.sv
// Shared types for the VDP1 CPU-bus initiator: FSM states, latched request
// and the field layout of the first address beat.
package vdp_bbus_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR_H = 3'd1,
    ADDR_L = 3'd2,
    DATA   = 3'd3,
    END    = 3'd4
  } state_t;

  typedef struct packed {
    logic [24:0] a;
    logic [1:0]  we;
    logic [15:0] d;
  } req_t;

  localparam int WR_BIT = 15;
  localparam int AH_MSB = 8;

  // First address beat: direction flag on top, upper address bits at the bottom.
  function automatic logic [15:0] addr_hi_beat(input logic [24:0] a, input logic [1:0] we);
    logic [15:0] beat;
    beat             = '0;
    beat[WR_BIT]     = |we;
    beat[AH_MSB:0]   = a[24:16];
    return beat;
  endfunction

endpackage

// File: rtl/vdp_bbus_master.sv
// Single-word initiator for the VDP1 multiplexed CPU bus: two address beats,
// then a data beat held until RDY_N. Optional watchdog: VDP_BBUS_TIMEOUT_EN.
module vdp_bbus_master
  import vdp_bbus_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE_R,
  input  logic        REQ,
  input  logic [24:0] REQ_A,
  input  logic [1:0]  REQ_WE,
  input  logic [15:0] REQ_D,
  output logic [15:0] RDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [15:0] BUS_DO,
  input  logic [15:0] BUS_DI,
  output logic        BUS_OE,
  output logic        CS_N,
  output logic        AD_N,
  output logic        DTEN_N,
  output logic [1:0]  WE_N,
  input  logic        RDY_N,
  output logic [2:0]  DBG_STATE
);

  // Handshake: REQ is a one-CLK pulse taken only while BUSY=0; BUSY then holds
  // until the CLK on which DONE pulses, and RDATA is valid with that DONE.

  state_t      state, state_nxt;
  req_t        req_q;
  logic        busy_q, done_q, err_q;
  logic [15:0] rdata_q;
  logic        is_wr;
  logic        to_hit;
  logic        go_end;

  assign is_wr  = |req_q.we;
  assign go_end = CE_R && (state == DATA) && (!RDY_N || to_hit);

`ifdef VDP_BBUS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      to_cnt <= '0;
    end else if (CE_R) begin
      if (state == ADDR_L)
        to_cnt <= '0;
      else if (state == DATA && RDY_N)
        to_cnt <= to_cnt + 1'b1;
    end
  end

  assign to_hit = (state == DATA) && RDY_N && (to_cnt == TO_LAST);
`else
  // Without the watchdog DATA waits forever; TIMEOUT has no effect.
  assign to_hit = (TIMEOUT < 0);
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      req_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= go_end;
      err_q  <= go_end && RDY_N;
      if (REQ && !busy_q) begin
        req_q  <= '{a: REQ_A, we: REQ_WE, d: REQ_D};
        busy_q <= 1'b1;
      end else if (go_end) begin
        busy_q <= 1'b0;
      end
      // A completion with RDY_N still high can only be a watchdog abort.
      if (go_end && !is_wr)
        rdata_q <= RDY_N ? 16'hFFFF : BUS_DI;
    end
  end

  always_comb begin
    state_nxt = state;
    CS_N      = 1'b1;
    AD_N      = 1'b1;
    DTEN_N    = 1'b1;
    WE_N      = 2'b11;
    BUS_OE    = 1'b0;
    BUS_DO    = '0;
    case (state)
      IDLE: begin
        if (CE_R && busy_q) state_nxt = ADDR_H;
      end
      ADDR_H: begin
        CS_N   = 1'b0;
        AD_N   = 1'b0;
        BUS_OE = 1'b1;
        BUS_DO = addr_hi_beat(req_q.a, req_q.we);
        if (CE_R) state_nxt = ADDR_L;
      end
      ADDR_L: begin
        CS_N   = 1'b0;
        AD_N   = 1'b0;
        BUS_OE = 1'b1;
        BUS_DO = req_q.a[15:0];
        if (CE_R) state_nxt = DATA;
      end
      DATA: begin
        CS_N   = 1'b0;
        DTEN_N = 1'b0;
        if (is_wr) begin
          BUS_OE = 1'b1;
          BUS_DO = req_q.d;
          WE_N   = ~req_q.we;
        end
        if (go_end) state_nxt = END;
      end
      END: begin
        if (CE_R) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign RDATA     = rdata_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign DBG_STATE = state;

endmodule

// File: tb/tb_vdp_bbus_master.sv
// Self-checking bench for vdp_bbus_master: directed and randomized transfers
// compared against a phase-count model of the bus protocol.
module tb_vdp_bbus_master;

  localparam int TO = 4;
`ifdef VDP_BBUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // clock / reset
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST, CE_R, REQ, BUS_OE, CS_N, AD_N, DTEN_N, RDY_N;
  logic        BUSY, DONE, ERR;
  logic [24:0] REQ_A;
  logic [1:0]  REQ_WE, WE_N;
  logic [15:0] REQ_D, RDATA, BUS_DO, BUS_DI;
  logic [2:0]  dbg_state;

  vdp_bbus_master #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .CE_R(CE_R), .REQ(REQ), .REQ_A(REQ_A),
    .REQ_WE(REQ_WE), .REQ_D(REQ_D), .RDATA(RDATA), .BUSY(BUSY), .DONE(DONE),
    .ERR(ERR), .BUS_DO(BUS_DO), .BUS_DI(BUS_DI), .BUS_OE(BUS_OE), .CS_N(CS_N),
    .AD_N(AD_N), .DTEN_N(DTEN_N), .WE_N(WE_N), .RDY_N(RDY_N),
    .DBG_STATE(dbg_state)
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  logic [15:0] last_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] strobes();
    return {CS_N, AD_N, DTEN_N, WE_N, BUS_OE};
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_strobes"}, strobes(), 6'b111110);
    check({tag, "_bus_do"}, BUS_DO, 16'h0);
    check({tag, "_busy"}, BUSY, 1'b0);
    check({tag, "_done"}, DONE, 1'b0);
    check({tag, "_err"}, ERR, 1'b0);
    check({tag, "_rdata"}, RDATA, 16'h0);
  endtask

  // Model: count CE_R ticks since the request was taken. Tick 1 is the high
  // address beat, tick 2 the low beat, ticks 3.. the data beat (one extra tick
  // per RDY_N-high tick), then one END tick, then idle. Called at a negedge.
  task automatic run_txn(input logic [24:0] a, input logic [1:0] we, input logic [15:0] d,
                         input int n_hi, input logic [15:0] di, input int ce_pct);
    int          ph, end_ph, cyc;
    bit          wr, to_hit, first, poked, in_data;
    logic [15:0] hi, new_rdata, exp_rdata;
    logic [5:0]  exp_s;
    wr        = (we != 2'b00);
    to_hit    = TO_EN && (n_hi >= TO);
    end_ph    = to_hit ? 3 + TO : 4 + n_hi;
    hi        = {wr, 6'b0, a[24:16]};
    new_rdata = wr ? last_rdata : (to_hit ? 16'hFFFF : di);

    REQ = 1'b1; REQ_A = a; REQ_WE = we; REQ_D = d;
    CE_R = 1'($urandom_range(0, 1)); RDY_N = 1'($urandom);
    @(negedge CLK);
    REQ = 1'b0; REQ_A = 25'($urandom); REQ_WE = 2'($urandom); REQ_D = 16'($urandom);

    ph = 0; first = 1'b0; poked = 1'b0;
    for (cyc = 0; cyc < 400; cyc++) begin
      in_data = (ph >= 3) && (ph < end_ph);
      if (ph == 1 || ph == 2)
        exp_s = 6'b001111;
      else if (in_data)
        exp_s = {3'b010, wr ? ~we : 2'b11, wr};
      else
        exp_s = 6'b111110;
      check("strobes", strobes(), exp_s);
      if (!(in_data && !wr))
        check("bus_do", BUS_DO, ph == 1 ? hi : ph == 2 ? a[15:0] : in_data ? d : 16'h0);
      check("busy", BUSY, ph < end_ph);
      check("done", DONE, (ph == end_ph) && first);
      check("err", ERR, (ph == end_ph) && first && to_hit);
      exp_rdata = (ph >= end_ph) ? new_rdata : last_rdata;
      check("rdata", RDATA, exp_rdata);
      if (ph > end_ph) break;

      CE_R   = ($urandom_range(1, 100) <= ce_pct);
      RDY_N  = in_data ? (ph - 3 < n_hi) : 1'($urandom);
      BUS_DI = in_data ? di : 16'($urandom);
      REQ    = (!poked && ph == 1);
      if (REQ) begin
        poked = 1'b1; REQ_A = 25'($urandom); REQ_WE = 2'($urandom); REQ_D = 16'($urandom);
      end
      @(posedge CLK);
      first = CE_R;
      if (CE_R) ph++;
      @(negedge CLK);
      REQ = 1'b0;
    end
    check("txn_bound", ph, end_ph + 1);
    last_rdata = new_rdata;
  endtask

  initial begin
    RST = 1'b1; CE_R = 1'b0; REQ = 1'b0; REQ_A = '0; REQ_WE = '0; REQ_D = '0;
    BUS_DI = '0; RDY_N = 1'b1;
    repeat (3) @(negedge CLK);
    check_reset_vals("reset");
    RST = 1'b0;
    last_rdata = 16'h0;
    @(negedge CLK);

    // Directed: full write, slow read, byte write, sparse CE_R.
    run_txn(25'h0100004, 2'b11, 16'hA55A, 0, 16'h0000, 100);
    run_txn(25'h0000010, 2'b00, 16'h0000, 3, 16'h1234, 100);
    run_txn(25'h1FFFFFE, 2'b10, 16'h00C3, 1, 16'h0000, 100);
    run_txn(25'h0123456, 2'b00, 16'h0000, 2, 16'hBEEF, 30);

    // Reset during DATA after an ignored second request.
    REQ = 1'b1; REQ_A = 25'h0ABCDE; REQ_WE = 2'b01; REQ_D = 16'h5555;
    CE_R = 1'b1; RDY_N = 1'b1;
    @(negedge CLK);
    REQ = 1'b0;
    @(negedge CLK);
    REQ = 1'b1; REQ_A = 25'h1000000; REQ_WE = 2'b11;
    @(negedge CLK);
    REQ = 1'b0;
    @(negedge CLK);
    check("rst_pre_data_dten", DTEN_N, 1'b0);
    check("rst_pre_data_do", BUS_DO, 16'h5555);
    RST = 1'b1;
    @(negedge CLK);
    check_reset_vals("rst_mid");
    RST = 1'b0; RDY_N = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      check("rst_no_done", DONE, 1'b0);
      check("rst_no_busy", BUSY, 1'b0);
      check("rst_idle_strobes", strobes(), 6'b111110);
    end
    last_rdata = 16'h0;

    for (int i = 0; i < 24; i++)
      run_txn(25'($urandom), 2'($urandom), 16'($urandom), $urandom_range(0, 2),
              16'($urandom), $urandom_range(40, 100));

    if (TO_EN) begin
      run_txn(25'h0000200, 2'b00, 16'h0000, 50, 16'h7777, 100);
      run_txn(25'h0000202, 2'b11, 16'h9999, 50, 16'h0000, 70);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
